ex_muldiv_seq: RTL and testbench
================================

EX_MULDIV_SEQ -- requirements
Module: ex_muldiv_seq

Interface
REQ-001 SHALL expose ports: clk  in  1  pipeline clock (all state on rising edge).
REQ-002 SHALL expose: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL expose: start  in  1  EX holds a valid RV32M instruction (funct7=0000001, R-type); held high while stalled.
REQ-004 SHALL expose: funct3  in  `FUNCT3_WIDTH  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL expose: op_a  in  `REG_DATA_WIDTH  forwarded rs1 data; op_b  in  `REG_DATA_WIDTH  forwarded rs2 data.
REQ-006 SHALL expose: flush  in  1  kill the EX instruction (branch taken/redirect).
REQ-007 SHALL expose: stall_req  out  1  freeze IF/ID/EX pipeline registers.
REQ-008 SHALL expose: busy  out  1  state != IDLE; done  out  1  result valid pulse; result  out  `REG_DATA_WIDTH  M-op result.

Function
REQ-009 SHALL implement FSM states IDLE, CALC, DONE.
REQ-010 SHALL, in IDLE with start=1 and flush=0, latch op_a, op_b, funct3, operand signs, clear 6-bit counter; next state CALC, or DONE for fast-path cases (REQ-015/016).
REQ-011 SHALL, in CALC, perform one radix-2 iteration per cycle on operand magnitudes (shift-add for MUL*, restoring shift-subtract for DIV*/REM*), incrementing counter; after iteration 31 (32nd CALC cycle) go to DONE.
REQ-012 SHALL, in DONE, assert done=1 for exactly one cycle, drive the sign-corrected result, then go to IDLE unconditionally (start still high in DONE SHALL NOT restart).
REQ-013 SHALL drive stall_req = (state==IDLE & start & !flush) | (state==CALC); stall_req=0 in DONE so the pipeline advances and captures result.
REQ-014 SHALL select result: MUL low 32 of product; MULH/MULHSU/MULHU high 32 with signed x signed / signed x unsigned / unsigned x unsigned; DIV/DIVU quotient; REM/REMU remainder; signed quotient negated when operand signs differ, remainder takes dividend sign.
REQ-015 SHALL treat op_b=0 for DIV*/REM* as fast path: quotient 0xFFFFFFFF, remainder = op_a, latency IDLE->DONE in one edge.
REQ-016 SHALL treat DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF as fast path: quotient 0x80000000, remainder 0.
REQ-017 SHALL hold result stable after DONE until the next accepted start.
REQ-018 SHALL, on flush in CALC or DONE, go to IDLE next edge, suppress done, drop stall_req in that same cycle; flush in IDLE blocks acceptance.
REQ-019 SHALL keep total latency fixed: 34 cycles from acceptance to done for iterative ops, 2 cycles for fast path (acceptance cycle counts as 1).

Reset
REQ-020 SHALL, on rst=1 at any edge including mid-CALC, enter IDLE, clear counter and internal accumulators, and drive stall_req=0, busy=0, done=0, result=0.
REQ-021 SHALL give rst priority over flush and start.

Structure
REQ-022 SHALL place M-extension funct3 codes, `FUNCT7_MULDIV and `MULDIV_ITER (32) in riscv_def.v.
REQ-023 SHALL split iteration datapath (accumulator, shift, add/subtract, magnitude/sign fix-up) into sub-module muldiv_core; FSM, counter and stall logic remain in ex_muldiv_seq.

Verification
REQ-024 MUL: op_a=7, op_b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB, done 34 cycles after acceptance, stall_req high for the 33 cycles before DONE.
REQ-025 MULHU: op_a=op_b=0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-026 DIV: op_a=-7, op_b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 0x80000000/1 -> 0x80000000.
REQ-027 DIVU by 0 with op_a=0x1234 -> 0xFFFFFFFF, done 2 cycles after acceptance; REM 0x80000000 % -1 -> 0 via fast path.
REQ-028 flush at CALC cycle 10 -> IDLE next edge, no done pulse, stall_req low; a new start then completes correctly.
REQ-029 rst asserted at CALC cycle 20 -> all outputs 0 next cycle; back-to-back starts after DONE each complete with correct independent results.

Source files
------------

// File: rtl/ex_muldiv_seq_pkg.sv
// Shared constants and types for the sequential RV32M multiply/divide unit.
package ex_muldiv_seq_pkg;

    localparam int unsigned REG_DATA_WIDTH = 32;
    localparam int unsigned FUNCT3_WIDTH   = 3;
    localparam int unsigned MULDIV_ITER    = 32;
    localparam int unsigned CNT_WIDTH      = 6;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } m_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } state_e;

    // Divide-by-zero and signed overflow bypass the iterative datapath.
    function automatic logic is_fast_path(input logic [FUNCT3_WIDTH-1:0] f3,
                                          input logic [REG_DATA_WIDTH-1:0] a,
                                          input logic [REG_DATA_WIDTH-1:0] b);
        logic w_div_zero;
        logic w_ovf;
        w_div_zero = f3[2] & (b == '0);
        w_ovf      = f3[2] & ~f3[0] & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
        return w_div_zero | w_ovf;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 multiply/divide datapath: operand magnitudes, shift-add or restoring
// shift-subtract per step, and final sign correction / fast-path result.
module muldiv_core
    import ex_muldiv_seq_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      step,
    input  logic [FUNCT3_WIDTH-1:0]   funct3,
    input  logic [REG_DATA_WIDTH-1:0] op_a,
    input  logic [REG_DATA_WIDTH-1:0] op_b,
    output logic                      fast,
    output logic [REG_DATA_WIDTH-1:0] result
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opnd;
    m_op_e       r_op;
    logic        r_neg;
    logic        r_fast;
    logic [31:0] r_fast_res;

    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_ma;
    logic [31:0] w_mb;
    logic [31:0] w_fast_res;
    logic [32:0] w_sum;
    logic [32:0] w_rsh;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [63:0] w_prod_fix;
    logic [31:0] w_fix;

    assign w_a_signed = (funct3 == OpMulh) | (funct3 == OpMulhsu) |
                        (funct3 == OpDiv)  | (funct3 == OpRem);
    assign w_b_signed = (funct3 == OpMulh) | (funct3 == OpDiv) | (funct3 == OpRem);
    assign w_sa       = w_a_signed & op_a[31];
    assign w_sb       = w_b_signed & op_b[31];
    assign w_ma       = w_sa ? (~op_a + 32'd1) : op_a;
    assign w_mb       = w_sb ? (~op_b + 32'd1) : op_b;

    assign fast = is_fast_path(funct3, op_a, op_b);

    always_comb begin
        w_fast_res = '0;
        if (op_b == '0) begin
            w_fast_res = funct3[1] ? op_a : 32'hFFFF_FFFF;
        end else begin
            w_fast_res = funct3[1] ? 32'h0 : 32'h8000_0000;
        end
    end

    assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_rsh  = {r_hi, r_lo[31]};
    assign w_diff = w_rsh - {1'b0, r_opnd};
    assign w_ge   = (w_rsh >= {1'b0, r_opnd});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_opnd     <= '0;
            r_op       <= OpMul;
            r_neg      <= 1'b0;
            r_fast     <= 1'b0;
            r_fast_res <= '0;
        end else if (load) begin
            r_hi       <= '0;
            r_op       <= m_op_e'(funct3);
            r_fast     <= fast;
            r_fast_res <= w_fast_res;
            // Remainders follow the dividend sign; everything else follows sa^sb.
            r_neg      <= (funct3[2] & funct3[1]) ? w_sa : (w_sa ^ w_sb);
            if (funct3[2]) begin
                r_lo   <= w_ma;
                r_opnd <= w_mb;
            end else begin
                r_lo   <= w_mb;
                r_opnd <= w_ma;
            end
        end else if (step) begin
            if (r_op[2]) begin
                r_hi <= w_ge ? w_diff[31:0] : w_rsh[31:0];
                r_lo <= {r_lo[30:0], w_ge};
            end else begin
                r_hi <= w_sum[32:1];
                r_lo <= {w_sum[0], r_lo[31:1]};
            end
        end
    end

    assign w_prod_fix = r_neg ? (~{r_hi, r_lo} + 64'd1) : {r_hi, r_lo};

    always_comb begin
        w_fix = '0;
        case (r_op)
            OpMul:              w_fix = r_lo;
            OpMulh, OpMulhsu:   w_fix = w_prod_fix[63:32];
            OpMulhu:            w_fix = r_hi;
            OpDiv, OpDivu:      w_fix = r_neg ? (~r_lo + 32'd1) : r_lo;
            OpRem, OpRemu:      w_fix = r_neg ? (~r_hi + 32'd1) : r_hi;
            default:            w_fix = '0;
        endcase
    end

    assign result = r_fast ? r_fast_res : w_fix;

endmodule

// File: rtl/ex_muldiv_seq.sv
// EX-stage sequential RV32M unit: IDLE/CALC/DONE control, iteration counter
// and pipeline stall generation around the muldiv_core datapath.
module ex_muldiv_seq
    import ex_muldiv_seq_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [FUNCT3_WIDTH-1:0]   funct3,
    input  logic [REG_DATA_WIDTH-1:0] op_a,
    input  logic [REG_DATA_WIDTH-1:0] op_b,
    input  logic                      flush,
    output logic                      stall_req,
    output logic                      busy,
    output logic                      done,
    output logic [REG_DATA_WIDTH-1:0] result
);

    localparam logic [CNT_WIDTH-1:0] LastIter = CNT_WIDTH'(MULDIV_ITER - 1);

    state_e                    r_state;
    logic [CNT_WIDTH-1:0]      r_cnt;
    logic [REG_DATA_WIDTH-1:0] r_result;

    logic                      w_accept;
    logic                      w_step;
    logic                      w_fast;
    logic [REG_DATA_WIDTH-1:0] w_core_result;

    assign w_accept = (r_state == StIdle) & start & ~flush;
    assign w_step   = (r_state == StCalc) & ~flush;

    muldiv_core u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (w_accept),
        .step   (w_step),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .fast   (w_fast),
        .result (w_core_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_state <= w_fast ? StDone : StCalc;
                    end
                end
                StCalc: begin
                    if (flush) begin
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LastIter) begin
                            r_state <= StDone;
                        end
                    end
                end
                StDone: begin
                    // Keep the delivered value visible until the next op completes.
                    if (!flush) begin
                        r_result <= w_core_result;
                    end
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign stall_req = ~rst & ~flush & (((r_state == StIdle) & start) | (r_state == StCalc));
    assign busy      = (r_state != StIdle);
    assign done      = (r_state == StDone) & ~flush;
    assign result    = (r_state == StDone) ? w_core_result : r_result;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Randomized self-checking bench for ex_muldiv_seq against an arithmetic model.
module tb_ex_muldiv_seq;
    import ex_muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    ex_muldiv_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub;
        logic [63:0]        p;
        logic signed [31:0] as, bs;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        as = a;
        bs = b;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return as / bs;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return as % bs;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3 >= 3'd4 && b == 0) return 2;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Issues one op, holds start through DONE, then checks completion behaviour.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int          n;
        int          stalls;
        int          lat;
        bit          seen;
        logic [31:0] exp;
        exp = ref_model(f3, a, b);
        lat = ref_latency(f3, a, b);
        @(negedge clk);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b;
        #1;
        n = 1; stalls = 0; seen = 1'b0;
        while (n < 100 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (stall_req) stalls++;
                @(posedge clk); #1;
                n++;
            end
        end
        check_eq({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        if (seen) begin
            check_eq({tag, "_result"}, result, exp);
            check_eq({tag, "_latency"}, n, lat);
            check_eq({tag, "_stall_cycles"}, stalls, lat - 1);
            check_eq({tag, "_stall_in_done"}, {31'b0, stall_req}, 32'd0);
            @(posedge clk); #1;
            check_eq({tag, "_no_restart"}, {30'b0, busy, done}, 32'd0);
            start = 1'b0;
            @(posedge clk); #1;
            check_eq({tag, "_held"}, result, exp);
        end else begin
            start = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int pulses;
        rst = 1'b1; start = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0; flush = 1'b0;
        $display("M-extension funct7 = %b, iterations = %0d", FUNCT7_MULDIV, MULDIV_ITER);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", {29'b0, stall_req, busy, done}, 32'd0);
        check_eq("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ones");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_op(3'd5, 32'h8000_0000, 32'd1, "divu_min_1");
        run_op(3'd5, 32'h0000_1234, 32'd0, "divu_by0");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(3'd7, 32'h0000_0055, 32'd0, "remu_by0");
        run_op(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "mulhsu_m2");

        // Flush in IDLE must block acceptance.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4;
        #1;
        check_eq("idle_flush_stall", {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1;
        check_eq("idle_flush_busy", {31'b0, busy}, 32'd0);
        start = 1'b0; flush = 1'b0;

        // Flush at CALC cycle 10.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7;
        n = 1;
        while (n < 11) begin
            @(posedge clk); #1;
            n++;
        end
        flush = 1'b1;
        #1;
        check_eq("flush_stall_drop", {31'b0, stall_req}, 32'd0);
        check_eq("flush_busy_calc", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        check_eq("flush_to_idle", {31'b0, busy}, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check_eq("flush_no_done", pulses, 0);
        run_op(3'd4, 32'd1000, 32'd7, "after_flush_div");

        // Reset at CALC cycle 20.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd2; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
        n = 1;
        while (n < 21) begin
            @(posedge clk); #1;
            n++;
        end
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check_eq("midcalc_rst_ctrl", {29'b0, stall_req, busy, done}, 32'd0);
        check_eq("midcalc_rst_result", result, 32'd0);
        rst = 1'b0;
        run_op(3'd2, 32'h1234_5678, 32'h9ABC_DEF0, "after_rst_mulhsu");

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op(f3, a, b, $sformatf("rand%0d_f%0d", i, f3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
